regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources:
//  ALU writeback and LSU load writeback. Each source gets a one-entry holding
//  buffer with a valid/ready handshake; an arbiter with starvation protection
//  and write-after-write (WAW) ordering drains the buffers into registered port
//  outputs. Sits between the EX/MEM writeback stages and registerFile; also
//  exports a pending-register mask for the hazard unit.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive lost cycles after which the ALU entry is forced to win
//  CNT_W         3  width of the starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   asynchronous, active-low reset (0 = reset)
//  alu_valid      in   1   ALU writeback request
//  alu_ready      out  1   ALU buffer can accept this cycle
//  alu_rd         in   5   ALU destination register
//  alu_data       in   32  ALU result
//  lsu_valid      in   1   load writeback request
//  lsu_ready      out  1   LSU buffer can accept this cycle
//  lsu_rd         in   5   load destination register
//  lsu_data       in   32  load data
//  rf_writeEnable out  1   to registerFile.writeEnable (registered)
//  rf_rd          out  5   to registerFile.rd (registered)
//  rf_writeData   out  32  to registerFile.writeData (registered)
//  pending_mask   out  32  bit r set = a write to x[r] is buffered or on the port
// BEHAVIOUR
//  Reset (rst=0, async): clear both buffer valids, the age bit and the starvation
//   counter; rf_writeEnable=0, rf_rd=0, rf_writeData=0, pending_mask=0.
//   A reset mid-operation discards buffered writes; they are not replayed.
//  Handshake: transfer when X_valid & X_ready at posedge; the entry is captured
//   into buf_X. X_ready = !bufX_v | grant_X (drain and refill in the same cycle
//   is allowed). X_ready is independent of X_valid (no combinational loop).
//  rd==0: the handshake completes (ready as usual), but the entry is not stored.
//   It never drives the port and never sets pending_mask[0].
//  Grant (combinational, from buffer state only):
//   - Only one buffer valid -> that buffer wins.
//   - Both valid and same rd -> the older entry wins (age bit); if both were
//     captured in the same cycle, the ALU entry counts as older.
//   - Both valid, different rd, starve_cnt==STARVE_LIMIT -> ALU wins.
//   - Otherwise -> LSU wins.
//  starve_cnt: +1 each cycle the ALU buffer is valid and loses; clears when the
//   ALU wins or its buffer is empty; saturates at STARVE_LIMIT.
//  Port register: each posedge, rf_writeEnable<=|grant and rf_rd/rf_writeData<=
//   the winner's fields; with no grant, writeEnable<=0 and rd/data hold.
//  Latency: accepted at edge N -> on port after edge N+1 at the earliest ->
//   registerFile writes at edge N+2. Throughput: 1 write/cycle total.
//  pending_mask = onehot(bufA.rd)&bufA_v | onehot(bufL.rd)&bufL_v
//   | onehot(rf_rd)&rf_writeEnable.
//  Never drop a write; never reorder two writes to the same rd.
// STRUCTURE
//  Shared package rv_core_pkg: REG_ADDR_W=5, XLEN=32, typedef wb_req_t
//   {rd, data}.
//  One natural sub-module: wb_hold_buf (valid/ready one-entry buffer),
//   instantiated twice. Grant, age and starvation logic and the port register
//   live in the top module.
// TESTING
//  1. Reset held, then release; no requests -> all outputs 0, both readies 1.
//  2. ALU {rd=5, data=0x11} alone -> port shows we=1, rd=5, 0x11 two edges
//     later; pending_mask[5]=1 until the port clears.
//  3. Both valid same cycle: ALU rd=3 and LSU rd=7 -> LSU 7 written first, then
//     ALU 3; alu_ready=0 for one cycle.
//  4. LSU request every cycle while ALU rd=9 waits -> ALU wins on cycle
//     STARVE_LIMIT+1, i.e. no ALU wait longer than 4 lost cycles.
//  5. ALU rd=4 data=0xA captured one cycle before LSU rd=4 data=0xB -> port
//     order is 0xA then 0xB, and x4 ends as 0xB.
//  6. rd=0 request -> handshake completes, we stays 0. Assert rst mid-burst ->
//     outputs 0 immediately, and the buffered entries never appear on the port.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core types: register address/data widths and the writeback request payload.
package rv_core_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32'(1) << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot = NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with valid/ready intake; x0 writes are accepted but dropped.
module wb_hold_buf
  import rv_core_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    drain,
  output logic    ready_c,
  output logic    load_c,
  output logic    buf_valid,
  output wb_req_t buf_req
);

  // Ready ignores in_valid so upstream never sees a combinational loop.
  assign ready_c = !buf_valid | drain;
  assign load_c  = in_valid & ready_c & (in_req.rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_req   <= '0;
    end else if (load_c) begin
      buf_valid <= 1'b1;
      buf_req   <= in_req;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and LSU writebacks onto the single register-file write port,
// keeping same-rd writes in order and bounding ALU starvation.
module regfile_write_arbiter
  import rv_core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  rf_writeEnable,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_writeData,
  output logic [NUM_REGS-1:0]   pending_mask
);

  wb_req_t    alu_req_in, lsu_req_in, alu_buf, lsu_buf;
  logic       alu_v, lsu_v, alu_load, lsu_load;
  logic       grant_alu, grant_lsu;
  logic       lsu_older;
  logic [CNT_W-1:0] starve_cnt;

  assign alu_req_in = '{rd: alu_rd, data: alu_data};
  assign lsu_req_in = '{rd: lsu_rd, data: lsu_data};

  wb_hold_buf u_alu_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (alu_valid),
    .in_req    (alu_req_in),
    .drain     (grant_alu),
    .ready_c   (alu_ready),
    .load_c    (alu_load),
    .buf_valid (alu_v),
    .buf_req   (alu_buf)
  );

  wb_hold_buf u_lsu_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (lsu_valid),
    .in_req    (lsu_req_in),
    .drain     (grant_lsu),
    .ready_c   (lsu_ready),
    .load_c    (lsu_load),
    .buf_valid (lsu_v),
    .buf_req   (lsu_buf)
  );

  // Grant from buffer state only: same-rd goes by age, else LSU unless ALU is starved.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (alu_v && lsu_v) begin
      if (alu_buf.rd == lsu_buf.rd) begin
        if (lsu_older) grant_lsu = 1'b1;
        else           grant_alu = 1'b1;
      end else if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
        grant_alu = 1'b1;
      end else begin
        grant_lsu = 1'b1;
      end
    end else if (alu_v) begin
      grant_alu = 1'b1;
    end else if (lsu_v) begin
      grant_lsu = 1'b1;
    end
  end

  // Age tracks which surviving entry arrived first; a simultaneous capture counts ALU as older.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_older <= 1'b0;
    end else if (alu_load && lsu_load) begin
      lsu_older <= 1'b0;
    end else if (alu_load && lsu_v && !grant_lsu) begin
      lsu_older <= 1'b1;
    end else if (lsu_load && alu_v && !grant_alu) begin
      lsu_older <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (alu_v && !grant_alu) begin
      if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Write-port register: address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_writeEnable <= 1'b0;
      rf_rd          <= '0;
      rf_writeData   <= '0;
    end else begin
      rf_writeEnable <= grant_alu | grant_lsu;
      if (grant_alu) begin
        rf_rd        <= alu_buf.rd;
        rf_writeData <= alu_buf.data;
      end else if (grant_lsu) begin
        rf_rd        <= lsu_buf.rd;
        rf_writeData <= lsu_buf.data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (alu_v)          pending_mask = pending_mask | rd_onehot(alu_buf.rd);
    if (lsu_v)          pending_mask = pending_mask | rd_onehot(lsu_buf.rd);
    if (rf_writeEnable) pending_mask = pending_mask | rd_onehot(rf_rd);
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed port sequences.
module tb_regfile_write_arbiter;

  logic        clk, rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rf_rd;
  logic [31:0] alu_data, lsu_data, rf_writeData, pending_mask;
  logic        rf_writeEnable;
  logic [31:0] shadow [32];
  int          checks = 0;
  int          errors = 0;
  logic        acc;
  int          exp_rd [5] = '{10, 11, 12, 13, 9};

  regfile_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .lsu_valid      (lsu_valid),
    .lsu_ready      (lsu_ready),
    .lsu_rd         (lsu_rd),
    .lsu_data       (lsu_data),
    .rf_writeEnable (rf_writeEnable),
    .rf_rd          (rf_rd),
    .rf_writeData   (rf_writeData),
    .pending_mask   (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model fed by the write port.
  always @(posedge clk) if (rf_writeEnable) shadow[rf_rd] <= rf_writeData;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    // 1: reset and idle
    repeat (3) tick();
    chk("rst_we",   32'(rf_writeEnable), 0);
    chk("rst_mask", pending_mask, 0);
    rst = 1'b1;
    repeat (2) tick();
    chk("idle_we",   32'(rf_writeEnable), 0);
    chk("idle_rd",   32'(rf_rd), 0);
    chk("idle_data", rf_writeData, 0);
    chk("idle_mask", pending_mask, 0);
    chk("idle_ardy", 32'(alu_ready), 1);
    chk("idle_lrdy", 32'(lsu_ready), 1);

    // 2: lone ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    tick();
    alu_valid = 1'b0;
    chk("t2_we0",   32'(rf_writeEnable), 0);
    chk("t2_mask0", pending_mask, 32'h20);
    tick();
    chk("t2_we1",   32'(rf_writeEnable), 1);
    chk("t2_rd",    32'(rf_rd), 5);
    chk("t2_data",  rf_writeData, 32'h11);
    chk("t2_mask1", pending_mask, 32'h20);
    tick();
    chk("t2_we2",   32'(rf_writeEnable), 0);
    chk("t2_mask2", pending_mask, 0);
    chk("t2_hold",  32'(rf_rd), 5);

    // 3: simultaneous, different rd -> LSU first
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("t3_ardy0", 32'(alu_ready), 0);
    chk("t3_lrdy0", 32'(lsu_ready), 1);
    chk("t3_mask0", pending_mask, 32'h88);
    tick();
    chk("t3_rd_a",   32'(rf_rd), 7);
    chk("t3_data_a", rf_writeData, 32'h77);
    chk("t3_ardy1",  32'(alu_ready), 1);
    chk("t3_mask1",  pending_mask, 32'h88);
    tick();
    chk("t3_we_b",   32'(rf_writeEnable), 1);
    chk("t3_rd_b",   32'(rf_rd), 3);
    chk("t3_data_b", rf_writeData, 32'h33);
    tick();
    chk("t3_we_c",   32'(rf_writeEnable), 0);

    // 4: LSU streams, ALU rd=9 forced through after 4 lost cycles
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h110;
    tick();
    alu_valid = 1'b0; lsu_rd = 5'd11; lsu_data = 32'h111;
    for (int i = 0; i < 5; i++) begin
      acc = lsu_valid && lsu_ready;
      if (i == 4) chk("t4_lrdy_stall", 32'(lsu_ready), 0);
      tick();
      if (acc) begin
        lsu_rd   = 5'(lsu_rd + 5'd1);
        lsu_data = lsu_data + 32'd1;
      end
      chk("t4_we", 32'(rf_writeEnable), 1);
      chk("t4_rd", 32'(rf_rd), 32'(exp_rd[i]));
    end
    chk("t4_alu_data", rf_writeData, 32'h99);
    lsu_valid = 1'b0;
    tick();
    chk("t4_tail_rd",   32'(rf_rd), 14);
    chk("t4_tail_data", rf_writeData, 32'h114);
    tick();
    chk("t4_idle", 32'(rf_writeEnable), 0);

    // 5: WAW to x4, ALU captured first while LSU occupied with x6
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
    tick();
    alu_valid = 1'b0; lsu_rd = 5'd4; lsu_data = 32'hB;
    chk("t5_lrdy", 32'(lsu_ready), 1);
    tick();
    lsu_valid = 1'b0;
    chk("t5_rd6",  32'(rf_rd), 6);
    chk("t5_mask", pending_mask, 32'h50);
    tick();
    chk("t5_rd_a",   32'(rf_rd), 4);
    chk("t5_data_a", rf_writeData, 32'hA);
    tick();
    chk("t5_rd_b",   32'(rf_rd), 4);
    chk("t5_data_b", rf_writeData, 32'hB);
    tick();
    chk("t5_x4", shadow[4], 32'hB);
    chk("t5_we", 32'(rf_writeEnable), 0);

    // 6: rd=0 dropped, then reset mid-burst
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    chk("t6_ardy", 32'(alu_ready), 1);
    tick();
    alu_valid = 1'b0;
    chk("t6_mask0", pending_mask, 0);
    tick();
    chk("t6_we0", 32'(rf_writeEnable), 0);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("t6_burst_rd", 32'(rf_rd), 13);
    rst = 1'b0;
    #1;
    chk("t6_rst_we",   32'(rf_writeEnable), 0);
    chk("t6_rst_rd",   32'(rf_rd), 0);
    chk("t6_rst_data", rf_writeData, 0);
    chk("t6_rst_mask", pending_mask, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_post_we",   32'(rf_writeEnable), 0);
      chk("t6_post_mask", pending_mask, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
